// File: rtl/serial_parity_pkg.sv
// rtl/serial_parity_pkg.sv - shared frame definitions for the XOR parity link
package serial_parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Parity bit a transmitter sends for a word (zero-extended to 32 bits).
  function automatic logic parity_of(input logic [31:0] word, input logic odd);
    return (^word) ^ odd;
  endfunction

endpackage

// File: rtl/serial_parity_rx_outreg.sv
// rtl/serial_parity_rx_outreg.sv - output holding register with valid/ready and overrun
// Optional error counter enabled by SERIAL_PARITY_RX_ERR_CNT_EN.
module serial_parity_rx_outreg #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
`ifdef SERIAL_PARITY_RX_ERR_CNT_EN
  input  logic              err_clr,
  output logic [CNT_W-1:0]  err_count,
`endif
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_perr,
  input  logic              load_ferr,
  input  logic              rx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic              ovr_q, ovr_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    ovr_d   = load & valid_q & ~rx_ready;
    if (load) begin
      data_d  = load_data;
      perr_d  = load_perr;
      ferr_d  = load_ferr;
      valid_d = 1'b1;
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;

`ifdef SERIAL_PARITY_RX_ERR_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       inc;
  logic [CNT_W+1:0] sum;

  // A bad frame that also overwrites an unaccepted word counts twice.
  always_comb begin
    inc = {1'b0, load & (load_perr | load_ferr)} + {1'b0, ovr_d};
    sum = {2'b00, cnt_q} + {{CNT_W{1'b0}}, inc};
    if (err_clr) begin
      cnt_d = '0;
    end else if (sum > {2'b00, {CNT_W{1'b1}}}) begin
      cnt_d = {CNT_W{1'b1}};
    end else begin
      cnt_d = sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign err_count = cnt_q;
`endif

endmodule

// File: rtl/serial_parity_rx.sv
// rtl/serial_parity_rx.sv - XOR parity link receiver: start, DATA_W data (LSB first), parity, stop
// Optional error counter enabled by SERIAL_PARITY_RX_ERR_CNT_EN.
module serial_parity_rx
  import serial_parity_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ODD_PARITY = 0,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
`ifdef SERIAL_PARITY_RX_ERR_CNT_EN
  input  logic              err_clr,
  output logic [CNT_W-1:0]  err_count,
`endif
  input  logic              bit_en,
  input  logic              rx_in,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  rx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              acc_q, acc_d;
  logic              perr_q, perr_d;
  logic              load;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bit_en && rx_in == START_BIT) state_d = DATA;
      DATA:    if (bit_en && cnt_q == LAST_IDX) state_d = PARITY;
      PARITY:  if (bit_en) state_d = STOP;
      STOP:    if (bit_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load = (state_q == STOP) && bit_en;
  end

  // The accumulator is seeded with the parity sense so a clean frame leaves it equal to the parity bit.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    perr_d  = perr_q;
    if (bit_en) begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          acc_d = 1'(ODD_PARITY);
        end
        DATA: begin
          shift_d[cnt_q] = rx_in;
          acc_d          = acc_q ^ rx_in;
          cnt_d          = cnt_q + 1'b1;
        end
        PARITY:  perr_d = acc_q ^ rx_in;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      perr_q  <= perr_d;
    end
  end

  serial_parity_rx_outreg #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_outreg (
    .clk        (clk),
    .rst        (rst),
`ifdef SERIAL_PARITY_RX_ERR_CNT_EN
    .err_clr    (err_clr),
    .err_count  (err_count),
`endif
    .load       (load),
    .load_data  (shift_q),
    .load_perr  (perr_q),
    .load_ferr  (rx_in != STOP_BIT),
    .rx_ready   (rx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

endmodule

// File: tb/tb_serial_parity_rx.sv
// tb/tb_serial_parity_rx.sv - randomized and directed bench for serial_parity_rx (even and odd instances)
// Error-counter checks are included when SERIAL_PARITY_RX_ERR_CNT_EN is defined.
module tb_serial_parity_rx;
  import serial_parity_pkg::*;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst, bit_en, rx_in, rx_ready;
  logic [DW-1:0] data_e, data_o;
  logic          valid_e, valid_o, perr_e, perr_o, ferr_e, ferr_o, ov_e, ov_o;
`ifdef SERIAL_PARITY_RX_ERR_CNT_EN
  logic          err_clr;
  logic [7:0]    cnt_e;
  logic [1:0]    cnt_o;
`endif

  always #5 clk = ~clk;

  serial_parity_rx #(.DATA_W(DW), .ODD_PARITY(0), .CNT_W(8)) dut_e (
    .clk(clk), .rst(rst),
`ifdef SERIAL_PARITY_RX_ERR_CNT_EN
    .err_clr(err_clr), .err_count(cnt_e),
`endif
    .bit_en(bit_en), .rx_in(rx_in), .rx_data(data_e), .rx_valid(valid_e),
    .rx_ready(rx_ready), .parity_err(perr_e), .frame_err(ferr_e), .overrun(ov_e)
  );

  serial_parity_rx #(.DATA_W(DW), .ODD_PARITY(1), .CNT_W(2)) dut_o (
    .clk(clk), .rst(rst),
`ifdef SERIAL_PARITY_RX_ERR_CNT_EN
    .err_clr(err_clr), .err_count(cnt_o),
`endif
    .bit_en(bit_en), .rx_in(rx_in), .rx_data(data_o), .rx_valid(valid_o),
    .rx_ready(rx_ready), .parity_err(perr_o), .frame_err(ferr_o), .overrun(ov_o)
  );

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 0;
  bit rand_ready = 0;

  // Frame whose stop bit is on the line this cycle, and the frame being serialized.
  logic          stop_now;
  logic [DW-1:0] f_data, nxt_data;
  logic          f_pbit, f_sbit, nxt_pbit, nxt_sbit;

  logic [DW-1:0] m_data;
  logic          m_valid, m_perr_e, m_perr_o, m_ferr, m_ov;
  int            m_cnt_e, m_cnt_o;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Word-level model: a finished frame loads, acceptance clears, loading over an unaccepted word overruns.
  always @(posedge clk) begin
    if (rst) begin
      m_data = '0; m_valid = 0; m_perr_e = 0; m_perr_o = 0; m_ferr = 0; m_ov = 0;
      m_cnt_e = 0; m_cnt_o = 0;
    end else begin
      m_ov = stop_now && m_valid && !rx_ready;
      if (stop_now) begin
        m_data   = f_data;
        m_perr_e = (^f_data) ^ f_pbit;
        m_perr_o = !((^f_data) ^ f_pbit);
        m_ferr   = !f_sbit;
        m_valid  = 1;
      end else if (m_valid && rx_ready) begin
        m_valid = 0;
      end
`ifdef SERIAL_PARITY_RX_ERR_CNT_EN
      if (err_clr) begin
        m_cnt_e = 0;
        m_cnt_o = 0;
      end else begin
        m_cnt_e += int'(stop_now && (m_perr_e || m_ferr)) + int'(m_ov);
        m_cnt_o += int'(stop_now && (m_perr_o || m_ferr)) + int'(m_ov);
        if (m_cnt_e > 255) m_cnt_e = 255;
        if (m_cnt_o > 3) m_cnt_o = 3;
      end
`endif
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("even.rx_valid", valid_e, m_valid);
      check("even.rx_data", data_e, m_data);
      check("even.parity_err", perr_e, m_perr_e);
      check("even.frame_err", ferr_e, m_ferr);
      check("even.overrun", ov_e, m_ov);
      check("odd.rx_valid", valid_o, m_valid);
      check("odd.rx_data", data_o, m_data);
      check("odd.parity_err", perr_o, m_perr_o);
      check("odd.frame_err", ferr_o, m_ferr);
      check("odd.overrun", ov_o, m_ov);
`ifdef SERIAL_PARITY_RX_ERR_CNT_EN
      check("even.err_count", cnt_e, m_cnt_e[7:0]);
      check("odd.err_count", cnt_o, m_cnt_o[1:0]);
`endif
    end
  end

  task automatic drive_bit(input logic b, input logic last, input int gap);
    @(negedge clk);
    bit_en = 1; rx_in = b; stop_now = last;
    if (last) begin
      f_data = nxt_data; f_pbit = nxt_pbit; f_sbit = nxt_sbit;
    end
    if (rand_ready) rx_ready = ($urandom_range(0, 2) != 0);
`ifdef SERIAL_PARITY_RX_ERR_CNT_EN
    if (rand_ready) err_clr = ($urandom_range(0, 15) == 0);
`endif
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      bit_en = 0; rx_in = 1; stop_now = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bit_en = 0; rx_in = 1; stop_now = 0;
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic pbit, input logic sbit, input int gap);
    nxt_data = d; nxt_pbit = pbit; nxt_sbit = sbit;
    drive_bit(START_BIT, 0, gap);
    for (int i = 0; i < DW; i++) drive_bit(d[i], 0, gap);
    drive_bit(pbit, 0, gap);
    drive_bit(sbit, 1, 0);
  endtask

  initial begin
    rst = 1; bit_en = 0; rx_in = 1; rx_ready = 1; stop_now = 0;
    f_data = '0; f_pbit = 0; f_sbit = 1; nxt_data = '0; nxt_pbit = 0; nxt_sbit = 1;
`ifdef SERIAL_PARITY_RX_ERR_CNT_EN
    err_clr = 0;
`endif
    repeat (3) @(negedge clk);
    rst = 0;
    chk_en = 1;
    check("reset.rx_valid", valid_e, 0);
    check("reset.rx_data", data_e, 0);
    check("reset.overrun", ov_e, 0);
    check("pkg.parity_a5_even", parity_of(32'hA5, 1'b0), 0);
    check("pkg.parity_01_odd", parity_of(32'h01, 1'b1), 0);

    // 0xA5 even-correct: line 0,1,0,1,0,0,1,0,1,0,1
    send_frame(8'hA5, 1'b0, 1'b1, 0);
    idle(1);
    check("a5.valid_latency", valid_e, 1);
    check("a5.rx_data", data_e, 8'hA5);
    check("a5.perr_even", perr_e, 0);
    check("a5.perr_odd", perr_o, 1);
    check("a5.ferr", ferr_e, 0);
    idle(1);
    check("a5.valid_one_cycle", valid_e, 0);

    send_frame(8'hA5, 1'b1, 1'b1, 0);
    idle(1);
    check("a5p1.rx_data", data_e, 8'hA5);
    check("a5p1.perr_even", perr_e, 1);
    check("a5p1.perr_odd", perr_o, 0);

    // Bad stop bit followed back-to-back by a good frame
    send_frame(8'h3C, 1'b0, 1'b0, 0);
    @(posedge clk); #1;
    check("3c.frame_err", ferr_e, 1);
    check("3c.rx_data", data_e, 8'h3C);
    send_frame(8'h01, 1'b1, 1'b1, 0);
    idle(1);
    check("01.rx_data", data_e, 8'h01);
    check("01.frame_err", ferr_e, 0);
    check("01.parity_err", perr_e, 0);

    rx_ready = 0;
    send_frame(8'h11, 1'b0, 1'b1, 0);
    send_frame(8'h22, 1'b0, 1'b1, 0);
    idle(1);
    check("ovr.pulse", ov_e, 1);
    check("ovr.rx_data", data_e, 8'h22);
    idle(1);
    check("ovr.pulse_one_cycle", ov_e, 0);
    check("ovr.valid_held", valid_e, 1);
    rx_ready = 1;
    idle(1);
    check("ovr.valid_cleared", valid_e, 0);

    send_frame(8'h5A, 1'b0, 1'b1, 3);
    idle(1);
    check("sparse.rx_data", data_e, 8'h5A);
    check("sparse.valid", valid_e, 1);

    // Reset after the third data bit of a partial frame
    drive_bit(START_BIT, 0, 0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1, 0, 0);
    @(negedge clk);
    bit_en = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    idle(12);
    check("rstmid.no_valid", valid_e, 0);
    send_frame(8'h77, 1'b0, 1'b1, 0);
    idle(1);
    check("rstmid.rx_data", data_e, 8'h77);
    check("rstmid.valid", valid_e, 1);
    idle(2);

`ifdef SERIAL_PARITY_RX_ERR_CNT_EN
    err_clr = 1;
    idle(1);
    err_clr = 0;
    for (int i = 0; i < 3; i++) begin
      send_frame(8'h0F, 1'b1, 1'b1, 0);
      idle(1);
    end
    rx_ready = 0;
    send_frame(8'h03, 1'b0, 1'b1, 0);
    send_frame(8'h03, 1'b0, 1'b1, 0);
    idle(1);
    check("cnt.three_bad_one_ovr", cnt_e, 4);
    rx_ready = 1;
    idle(2);
`endif

    rand_ready = 1;
    for (int n = 0; n < 80; n++) begin
      logic [DW-1:0] d;
      logic pb, sb;
      d  = DW'($urandom);
      pb = parity_of(32'(d), 1'b0) ^ ($urandom_range(0, 5) == 0);
      sb = ($urandom_range(0, 5) != 0);
      send_frame(d, pb, sb, $urandom_range(0, 2));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      if ($urandom_range(0, 4) == 0) drive_bit(1'b1, 0, 0);
    end
    rand_ready = 0;
    rx_ready = 1;
`ifdef SERIAL_PARITY_RX_ERR_CNT_EN
    err_clr = 0;
`endif
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
